// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: register offsets, STATUS/CTRL bit indices and TX drain states for mmio_uart_bridge
package mmio_uart_pkg;
  localparam logic [1:0] OFS_STATUS = 2'd0;
  localparam logic [1:0] OFS_TX = 2'd1;
  localparam logic [1:0] OFS_RX = 2'd2;
  localparam logic [1:0] OFS_CTRL = 2'd3;
  localparam int ST_RX_NE = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_RX_OVR = 2;
  localparam int ST_TX_DROP = 3;
  localparam int ST_TX_IDLE = 4;
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam int CTRL_LOOP = 2;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_state_t;
  function automatic logic [7:0] sat8(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; when full, a same-cycle pop frees the slot for the push
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/mmio_uart_bridge.sv
// mmio_uart_bridge: MMIO window to uartTx/uartRx with FIFOs, sticky flags and irq; loopback under MMIO_UART_LOOPBACK_EN
module mmio_uart_bridge
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h200,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clock,
  input  logic        RST,
  input  logic [31:0] vaddr,
  input  logic [31:0] data,
  input  logic        memWE,
  input  logic        memRE,
  output logic [31:0] q,
  output logic        hit,
  output logic [7:0]  txByte,
  output logic        txWE,
  input  logic        txBusy,
  input  logic [7:0]  rxByte,
  input  logic        rxFin,
  output logic        irq
);
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  tx_state_t state, state_nx;
  logic [31:0] ofs_full, status;
  logic [1:0] ofs;
  logic [2:0] ctrl;
  logic [TW-1:0] timer;
  logic [7:0] rx_din, rx_head, tx_head;
  logic [RCW-1:0] rx_count;
  logic [TCW-1:0] tx_count;
  logic rd, wr, loop, loop_push, rx_fin_q, rx_edge, rx_push, rx_pop, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_full, tx_empty, tx_idle, rx_overrun, tx_drop, timeout, clr;
  logic unused_data;
  assign ofs_full = vaddr - BASE_ADDR;
  assign hit = ofs_full < 32'd4;
  assign ofs = ofs_full[1:0];
  assign rd = hit & memRE;
  assign wr = hit & memWE;
  assign clr = wr & (ofs == OFS_STATUS);
  assign unused_data = ^data[31:8];
`ifdef MMIO_UART_LOOPBACK_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
  assign loop = ctrl[CTRL_LOOP];
`else
  localparam logic [2:0] CTRL_MASK = 3'b111 ^ (3'b1 << CTRL_LOOP);
  assign loop = 1'b0;
`endif
  // loopback diverts the LOAD byte into RX and masks the real receiver
  assign loop_push = (state == LOAD) & loop;
  assign rx_edge = rxFin & ~rx_fin_q & ~loop;
  assign rx_push = rx_edge | loop_push;
  assign rx_din = loop_push ? tx_head : rxByte;
  assign rx_pop = rd & (ofs == OFS_RX);
  assign tx_push = wr & (ofs == OFS_TX);
  assign tx_pop = state == LOAD;
  assign tx_idle = tx_empty & (state == IDLE);
  assign txWE = (state == LOAD) & ~loop;
  assign txByte = txWE ? tx_head : 8'h0;
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
    .clock(clock), .RST(RST), .push(rx_push), .pop(rx_pop), .din(rx_din),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .clock(clock), .RST(RST), .push(tx_push), .pop(tx_pop), .din(data[7:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  always_comb begin
    state_nx = state;
    timeout = 1'b0;
    case (state)
      IDLE: state_nx = (~tx_empty & ~txBusy) ? LOAD : IDLE;
      LOAD: state_nx = loop ? IDLE : WAIT_BUSY;
      WAIT_BUSY: begin
        timeout = ~txBusy & (timer == TW'(BUSY_TIMEOUT - 1));
        state_nx = txBusy ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY;
      end
      default: state_nx = txBusy ? WAIT_DONE : IDLE;
    endcase
  end
  always_comb begin
    status = '0;
    status[ST_RX_NE] = ~rx_empty;
    status[ST_TX_FULL] = tx_full;
    status[ST_RX_OVR] = rx_overrun;
    status[ST_TX_DROP] = tx_drop;
    status[ST_TX_IDLE] = tx_idle;
    status[15:8] = sat8(9'(rx_count));
    status[23:16] = sat8(9'(tx_count));
  end
  assign q = ~hit ? 32'h0 :
             ofs == OFS_STATUS ? status :
             ofs == OFS_RX ? {24'h0, rx_empty ? 8'h0 : rx_head} :
             ofs == OFS_CTRL ? {29'h0, ctrl} : 32'h0;
  always_ff @(posedge clock) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
      rx_fin_q <= 1'b0;
      rx_overrun <= 1'b0;
      tx_drop <= 1'b0;
      ctrl <= '0;
      irq <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= (state == WAIT_BUSY) ? timer + 1'b1 : '0;
      rx_fin_q <= rxFin;
      rx_overrun <= (rx_overrun & ~(clr & data[ST_RX_OVR])) | (rx_push & rx_full & ~rx_pop);
      tx_drop <= (tx_drop & ~(clr & data[ST_TX_DROP])) | (tx_push & tx_full & ~tx_pop) | timeout;
      if (wr & (ofs == OFS_CTRL)) ctrl <= data[2:0] & CTRL_MASK;
      irq <= (ctrl[CTRL_RX_IE] & ~rx_empty) | (ctrl[CTRL_TX_IE] & tx_idle) | rx_overrun | tx_drop;
    end
  end
endmodule

// File: doc/mmio_uart_bridge.md
Name: mmio_uart_bridge

Overview:
Parametrised successor to the fixed-address UART decode inside the MMU. It sits between the CPU memory port and the uartTx/uartRx cores, adding buffered RX and TX FIFOs, sticky error flags and an interrupt output. It also adds a transmit-drain state machine, so software no longer polls TxBusy byte by byte. The MMU forwards accesses in the 4-byte window at BASE_ADDR to this block and muxes q when hit=1.

Parameters:
BASE_ADDR, 32'h200, byte address of register window (offsets +0..+3)
RX_DEPTH, 16, RX FIFO entries; power of 2, 2..256
TX_DEPTH, 16, TX FIFO entries; power of 2, 2..256
BUSY_TIMEOUT, 4, cycles to wait for txBusy to rise after txWE before abandoning the byte

Ports:
clock  in  1  system clock; the only clock
RST  in  1  synchronous active-high reset
vaddr  in  32  CPU byte address
data  in  32  CPU write data; only [7:0] used
memWE  in  1  write strobe, one cycle per access
memRE  in  1  read strobe, one cycle per access
q  out  32  read data, combinational from vaddr and current state
hit  out  1  vaddr within BASE_ADDR..BASE_ADDR+3
txByte  out  8  byte to uartTx.buffer
txWE  out  1  one-cycle write pulse to uartTx.we
txBusy  in  1  uartTx.busy2, synchronous to clock
rxByte  in  8  uartRx.buffer
rxFin  in  1  uartRx.fin level, synchronous to clock
irq  out  1  level interrupt

Behaviour:
- Reset values: q=0 when not hit; txWE=0; txByte=0; irq=0. Both FIFOs empty; sticky flags clear; CTRL=0; FSM in IDLE.
- Register map:
  - +0 STATUS (R): [0] rxNotEmpty, [1] txFull, [2] rxOverrun, [3] txDrop, [4] txIdle (TX FIFO empty and FSM IDLE), [15:8] rxCount, [23:16] txCount, rest 0.
  - +0 STATUS (W): write-1-to-clear on [2] and [3].
  - +1 TXDATA (W): push data[7:0]. If the FIFO is full, the byte is dropped and txDrop is set. Reads return 0.
  - +2 RXDATA (R): q={24'b0, head}. On the memRE clock edge the head is popped. If empty, q=0 and no pop. Writes are ignored.
  - +3 CTRL (RW): [0] rxIrqEn, [1] txIrqEn, [2] loopback (see Optional Feature).
- Counts saturate at 8 bits: depth 256 reports 255.
- RX push:
  - Trigger: rising edge of rxFin (registered previous value), so a multi-cycle fin pushes exactly once.
  - Push while full: the byte is dropped and rxOverrun is set.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged, order preserved.
  - Push and pop in the same cycle on a full FIFO: accepted, no overrun.
- TX drain FSM:
  - IDLE: if the TX FIFO is not empty and txBusy=0, go to LOAD.
  - LOAD (1 cycle): txWE=1, txByte=head, pop. Go to WAIT_BUSY with the timer cleared.
  - WAIT_BUSY: when txBusy=1, go to WAIT_DONE. If the timer reaches BUSY_TIMEOUT, set txDrop and go to IDLE.
  - WAIT_DONE: when txBusy=0, go to IDLE.
- TX throughput: at most one byte per uartTx frame. A CPU push in the same cycle as a LOAD pop is accepted when not full.
- A CPU push in the same cycle as a drain pop with the FIFO full is accepted: the pop frees the slot.
- irq = (rxIrqEn & rxNotEmpty) | (txIrqEn & txIdle) | rxOverrun | txDrop, registered (1-cycle latency).
- memWE and memRE with hit=0 have no effect.
- memWE and memRE both asserted at +2: the read is honoured, the write is ignored.
- Reset mid-frame: FIFOs and FSM clear immediately and txWE drops. The byte already handed to uartTx is not recalled.

Optional Feature:
- Macro: MMIO_UART_LOOPBACK_EN.
- When defined, CTRL[2]=1 enables loopback:
  - In LOAD, txWE stays 0 and the head byte is pushed into the RX FIFO instead, with the overrun rule applied.
  - The FSM returns LOAD->IDLE directly.
  - rxFin edges are ignored while loopback=1.
- When undefined, CTRL[2] reads 0 and writes to it are ignored; no loopback logic is built.

Decomposition:
- Package mmio_uart_pkg holds:
  - register offset localparams (OFS_STATUS=0, OFS_TX=1, OFS_RX=2, OFS_CTRL=3);
  - STATUS and CTRL bit indices;
  - typedef enum logic [1:0] tx_state_t {IDLE, LOAD, WAIT_BUSY, WAIT_DONE}.
- One sub-module, sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count; synchronous RST), instantiated twice.

Test Plan:
- Reset, then read +0 -> q=32'h0000_0010 (txIdle only); irq=0.
- Write 8'h41, 8'h42, 8'h43 to +1 with txBusy modelled as 10 cycles high starting 1 cycle after txWE -> three txWE pulses carrying 41, 42, 43 in order, each after txBusy falls. STATUS[23:16] steps 3->0 and txIdle returns to 1.
- Pulse rxFin 17 times with bytes 0x00..0x10, RX_DEPTH=16 -> rxCount=16 and rxOverrun=1. Reads of +2 return 0x00..0x0F; a 17th read returns 0 and rxCount stays 0. Writing 32'h4 to +0 clears the overrun.
- Hold txBusy=0 permanently and write 8'h55 -> txWE pulses once, then after 4 cycles txDrop=1 and irq=1 on the next cycle.
- Same-cycle rxFin rising edge and +2 read with rxCount=16 -> returns the oldest byte, rxCount stays 16, no overrun.
- With MMIO_UART_LOOPBACK_EN and CTRL=32'h5, write 8'h7E -> txWE never pulses, rxCount=1, irq=1, and reading +2 returns 32'h7E.
